// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifu_pkg;

    localparam int          WORD_W  = 32;
    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [3:0]  ALU_ADD = 4'd2;

    typedef enum logic [1:0] {
        NPC_SEQ,
        NPC_BR,
        NPC_JMP
    } npc_sel_e;

    // Minimal ALU slice: the fetch stage only ever issues ALU_ADD.
    function automatic logic [WORD_W-1:0] alu_op(
        input logic [3:0]        op,
        input logic [WORD_W-1:0] a,
        input logic [WORD_W-1:0] b
    );
        alu_op = (op == ALU_ADD) ? a + b : NOP;
    endfunction

endpackage

// File: rtl/ifu_imem.sv
// Word-addressed instruction ROM; word i holds 32'(i).
// IFU_BOUNDS_CHECK_EN adds addr_fault and forces NOP on bad addresses.
module ifu_imem
    import ifu_pkg::*;
#(
    parameter int    IMEM_DEPTH     = 128,
    parameter string IMEM_INIT_FILE = ""
) (
    input  logic [WORD_W-1:0] pc,
`ifdef IFU_BOUNDS_CHECK_EN
    output logic              addr_fault,
`endif
    output logic [WORD_W-1:0] instr
);

    localparam int IDX_W = $clog2(IMEM_DEPTH);

    // Contents are fixed at elaboration; an external image is not loadable here.
    if (IMEM_INIT_FILE != "") begin : g_init_file_unsupported
        $error("ifu_imem: IMEM_INIT_FILE images are not supported by this ROM");
    end

    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] rom_word;

    assign idx      = pc[IDX_W+1:2];
    assign rom_word = WORD_W'(idx);

`ifdef IFU_BOUNDS_CHECK_EN
    assign addr_fault = (pc[WORD_W-1:IDX_W+2] != '0) || (pc[1:0] != 2'b00);
    assign instr      = addr_fault ? NOP : rom_word;
`else
    // Upper PC bits fold away (modulo IMEM_DEPTH) and the byte offset is ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc[WORD_W-1:IDX_W+2], pc[1:0]};
    assign instr          = rom_word;
`endif

endmodule

// File: rtl/pc_fetch_stage.sv
// Single-cycle MIPS fetch: PC register, next-PC selection and instruction ROM.
// Define IFU_BOUNDS_CHECK_EN to add the AddrFault output.
module pc_fetch_stage
    import ifu_pkg::*;
#(
    parameter int          IMEM_DEPTH     = 128,
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter string       IMEM_INIT_FILE = ""
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        JumpSel,
    input  logic [31:0] InstructOffset,
    input  logic [25:0] JumpInstruction,
    input  logic [31:0] JumpRegister,
`ifdef IFU_BOUNDS_CHECK_EN
    output logic        AddrFault,
`endif
    output logic [31:0] Instruction,
    output logic [31:0] NextInstruct
);

    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] pc_plus4, branch_tgt, j_tgt, jump_in;
    npc_sel_e          npc_sel;
    logic              unused_offset_hi;

    assign pc_plus4   = pc_q + 32'd4;
    // Offset is a word count; bits [31:30] shift out.
    assign branch_tgt = alu_op(ALU_ADD, pc_q, {InstructOffset[29:0], 2'b00});
    assign unused_offset_hi = ^InstructOffset[31:30];
    assign j_tgt      = {pc_q[31:28], JumpInstruction, 2'b00};
    assign jump_in    = JumpSel ? JumpRegister : j_tgt;

    always_comb begin
        npc_sel = NPC_SEQ;
        if (Jump) begin
            npc_sel = NPC_JMP;
        end else if (Branch) begin
            npc_sel = NPC_BR;
        end

        pc_d = pc_plus4;
        case (npc_sel)
            NPC_BR:  pc_d = branch_tgt;
            NPC_JMP: pc_d = jump_in;
            default: pc_d = pc_plus4;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    ifu_imem #(
        .IMEM_DEPTH     (IMEM_DEPTH),
        .IMEM_INIT_FILE (IMEM_INIT_FILE)
    ) u_imem (
        .pc         (pc_q),
`ifdef IFU_BOUNDS_CHECK_EN
        .addr_fault (AddrFault),
`endif
        .instr      (Instruction)
    );

    assign NextInstruct = pc_plus4;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage (default IMEM_DEPTH=128, RESET_PC=0).
// Expectations follow IFU_BOUNDS_CHECK_EN when the macro is defined.
module tb_pc_fetch_stage;

    logic        Clk;
    logic        Reset;
    logic        Branch;
    logic        Jump;
    logic        JumpSel;
    logic [31:0] InstructOffset;
    logic [25:0] JumpInstruction;
    logic [31:0] JumpRegister;
    logic [31:0] Instruction;
    logic [31:0] NextInstruct;
`ifdef IFU_BOUNDS_CHECK_EN
    logic        AddrFault;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pc_fetch_stage dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Branch          (Branch),
        .Jump            (Jump),
        .JumpSel         (JumpSel),
        .InstructOffset  (InstructOffset),
        .JumpInstruction (JumpInstruction),
        .JumpRegister    (JumpRegister),
`ifdef IFU_BOUNDS_CHECK_EN
        .AddrFault       (AddrFault),
`endif
        .Instruction     (Instruction),
        .NextInstruct    (NextInstruct)
    );

    // Clock / reset block
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_fetch(input string tag, input logic [31:0] instr, input logic [31:0] nxt);
        check({tag, ".instr"}, Instruction, instr);
        check({tag, ".next"}, NextInstruct, nxt);
    endtask

    task automatic drive(input logic br, input logic j, input logic js, input logic [31:0] off,
                         input logic [25:0] ji, input logic [31:0] jr);
        Branch          = br;
        Jump            = j;
        JumpSel         = js;
        InstructOffset  = off;
        JumpInstruction = ji;
        JumpRegister    = jr;
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0);
        tick();
        expect_fetch("reset", 32'd0, 32'd4);
        Reset = 1'b0;

        // Sequential fetch
        tick(); expect_fetch("seq_pc4", 32'd1, 32'd8);
        tick(); expect_fetch("seq_pc8", 32'd2, 32'd12);
        tick(); expect_fetch("seq_pc12", 32'd3, 32'd16);
        tick(); expect_fetch("seq_pc16", 32'd4, 32'h14);

        // Branches from PC=0x10
        drive(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 26'h0, 32'h0);
        tick(); expect_fetch("br_back", 32'd2, 32'h0C);
        drive(1'b1, 1'b0, 1'b0, 32'd2, 26'h0, 32'h0);
        tick(); expect_fetch("br_fwd2", 32'd4, 32'h14);
        drive(1'b1, 1'b0, 1'b0, 32'd3, 26'h0, 32'h0);
        tick(); expect_fetch("br_fwd3", 32'd7, 32'h20);
        // Offset bits [31:30] fall off the shift: 0x1C + 4
        drive(1'b1, 1'b0, 1'b0, 32'h4000_0001, 26'h0, 32'h0);
        tick(); expect_fetch("br_offhi", 32'd8, 32'h24);
        drive(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 26'h0, 32'h0);
        tick(); expect_fetch("br_to_10", 32'd4, 32'h14);

        // J-type jump, then jump with branch also asserted
        drive(1'b0, 1'b1, 1'b0, 32'd0, 26'h40, 32'h0);
        tick(); expect_fetch("jmp", 32'h40, 32'h104);
        drive(1'b1, 1'b1, 1'b0, 32'd3, 26'h41, 32'h0);
        tick(); expect_fetch("jmp_over_br", 32'h41, 32'h108);

        // Jump register
        drive(1'b0, 1'b1, 1'b1, 32'd0, 26'h40, 32'h24);
        tick(); expect_fetch("jr", 32'd9, 32'h28);
`ifdef IFU_BOUNDS_CHECK_EN
        check("jr.fault", {31'd0, AddrFault}, 32'd0);
`endif

        // Reset with Jump asserted: no effect until the edge, then PC=0
        drive(1'b0, 1'b1, 1'b0, 32'd0, 26'h40, 32'h0);
        Reset = 1'b1;
        #2;
        expect_fetch("rst_pre_edge", 32'd9, 32'h28);
        tick(); expect_fetch("rst_mid", 32'd0, 32'd4);
        Reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 26'h0, 32'h0);
        tick(); expect_fetch("rst_resume", 32'd1, 32'd8);

        // Out-of-range, unaligned and wrapping PCs
        drive(1'b0, 1'b1, 1'b1, 32'd0, 26'h0, 32'h200);
        tick();
`ifdef IFU_BOUNDS_CHECK_EN
        expect_fetch("oob", 32'h0, 32'h204);
        check("oob.fault", {31'd0, AddrFault}, 32'd1);
`else
        expect_fetch("oob", 32'd0, 32'h204);
`endif
        drive(1'b0, 1'b1, 1'b1, 32'd0, 26'h0, 32'h25);
        tick();
`ifdef IFU_BOUNDS_CHECK_EN
        expect_fetch("unalign", 32'h0, 32'h29);
        check("unalign.fault", {31'd0, AddrFault}, 32'd1);
`else
        expect_fetch("unalign", 32'd9, 32'h29);
`endif
        drive(1'b0, 1'b1, 1'b1, 32'd0, 26'h0, 32'hFFFF_FFFC);
        tick();
`ifdef IFU_BOUNDS_CHECK_EN
        expect_fetch("top", 32'h0, 32'h0);
        check("top.fault", {31'd0, AddrFault}, 32'd1);
`else
        expect_fetch("top", 32'h7F, 32'h0);
`endif
        drive(1'b0, 1'b0, 1'b0, 32'd0, 26'h0, 32'h0);
        tick(); expect_fetch("wrap0", 32'd0, 32'd4);
`ifdef IFU_BOUNDS_CHECK_EN
        check("wrap0.fault", {31'd0, AddrFault}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
